// File: rtl/nibble_serial_add_if.sv
// rtl/nibble_serial_add_if.sv - requester handshake plus adder-slice bus for the nibble-serial add controller
interface nibble_serial_add_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_ci;
  logic [3:0]   add_s;
  logic         add_co;

  // Master is everything around the controller: the requester and the shared slice.
  modport master (
    output start, a, b, ci, add_s, add_co,
    input  ready, busy, done, sum, co, ovf, add_a, add_b, add_ci
  );

  modport slave (
    input  start, a, b, ci, add_s, add_co,
    output ready, busy, done, sum, co, ovf, add_a, add_b, add_ci
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - W-bit add sequenced one nibble per clock through an external 4-bit slice
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  nibble_serial_add_if.slave  bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            co_q, co_d;
  logic            ovf_q, ovf_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      nib_a, nib_b;

  always_comb begin
    nib_a   = a_q[{idx_q, 2'b00} +: 4];
    nib_b   = b_q[{idx_q, 2'b00} +: 4];
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.ci;
          idx_d   = '0;
          sum_d   = '0;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = bus.add_s;
        carry_d = bus.add_co;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          // Top slice's sum bit is the result sign; overflow when like-signed operands flip it.
          co_d    = bus.add_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (bus.add_s[3] != a_q[W-1]);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the next state, so they line up with state_q.
    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sum    = sum_q;
  assign bus.co     = co_q;
  assign bus.ovf    = ovf_q;
  assign bus.add_a  = busy_q ? nib_a : 4'd0;
  assign bus.add_b  = busy_q ? nib_b : 4'd0;
  assign bus.add_ci = busy_q ? carry_q : 1'b0;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed-vector bench for nibble_serial_add_ctrl (NIBBLES=4 and NIBBLES=1)
module tb_nibble_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_add_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_add_if #(.NIBBLES(1)) bus1 ();

  nibble_serial_add_ctrl #(.NIBBLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  nibble_serial_add_ctrl #(.NIBBLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // External 4-bit ripple slice models
  assign {bus4.add_co, bus4.add_s} = {1'b0, bus4.add_a} + {1'b0, bus4.add_b} + {4'd0, bus4.add_ci};
  assign {bus1.add_co, bus1.add_s} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {4'd0, bus1.add_ci};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                      output int cyc, output logic [15:0] sa, output logic [3:0] sci);
    bus4.a = av; bus4.b = bv; bus4.ci = civ; bus4.start = 1'b1;
    tick;
    bus4.start = 1'b0;
    cyc = 0; sa = '0; sci = '0;
    while (!bus4.done && cyc < 20) begin
      sa  = {sa[11:0], bus4.add_a};
      sci = {sci[2:0], bus4.add_ci};
      tick;
      cyc++;
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        ci;
    logic [15:0] sum;
    logic        co, ovf;
    logic [15:0] seq_a;
    logic [3:0]  seq_ci;
  } vec_t;

  vec_t vecs [4] = '{
    '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 16'h4321, 4'b0000},
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 4'b0111},
    '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 16'hFFF7, 4'b1111},
    '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 4'b0000}
  };

  vec_t cont [4] = '{
    '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 16'h0000, 4'b0000},
    '{16'h1000, 16'h2000, 1'b1, 16'h3001, 1'b0, 1'b0, 16'h0000, 4'b0000},
    '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 4'b0000},
    '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h0000, 4'b0000}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          ndone;
    logic [15:0] sa, got_sum;
    logic [3:0]  sci;
    int          expv;

    rst = 1'b1;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.ci = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0;
    tick; tick;
    rst = 1'b0;

    check("rst_ready", bus4.ready, 1);
    check("rst_busy",  bus4.busy,  0);
    check("rst_done",  bus4.done,  0);
    check("rst_sum",   bus4.sum,   0);
    check("rst_co",    bus4.co,    0);
    check("rst_ovf",   bus4.ovf,   0);
    check("rst_add_a", bus4.add_a, 0);
    check("rst1_ready", bus1.ready, 1);

    foreach (vecs[i]) begin
      run4(vecs[i].a, vecs[i].b, vecs[i].ci, cyc, sa, sci);
      check($sformatf("v%0d_latency", i), cyc, 4);
      check($sformatf("v%0d_sum", i), bus4.sum, vecs[i].sum);
      check($sformatf("v%0d_co", i), bus4.co, vecs[i].co);
      check($sformatf("v%0d_ovf", i), bus4.ovf, vecs[i].ovf);
      check($sformatf("v%0d_seq_a", i), sa, vecs[i].seq_a);
      check($sformatf("v%0d_seq_ci", i), sci, vecs[i].seq_ci);
      tick;
      check($sformatf("v%0d_done_pulse", i), bus4.done, 0);
      check($sformatf("v%0d_sum_hold", i), bus4.sum, vecs[i].sum);
    end

    // start during RUN must be ignored
    bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.ci = 1'b0; bus4.start = 1'b1;
    tick;
    bus4.start = 1'b0;
    tick;
    bus4.a = 16'hAAAA; bus4.b = 16'h5555; bus4.start = 1'b1;
    tick;
    bus4.start = 1'b0;
    ndone = 0; got_sum = '0;
    for (int k = 0; k < 10; k++) begin
      if (bus4.done) begin ndone++; got_sum = bus4.sum; end
      tick;
    end
    check("ign_done_count", ndone, 1);
    check("ign_sum", got_sum, 16'h3333);

    // reset in RUN cycle 3
    bus4.a = 16'h0F0F; bus4.b = 16'h0101; bus4.ci = 1'b0; bus4.start = 1'b1;
    tick;
    bus4.start = 1'b0;
    tick; tick;
    check("midrst_partial_busy", bus4.busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_ready", bus4.ready, 1);
    check("midrst_busy",  bus4.busy,  0);
    check("midrst_done",  bus4.done,  0);
    check("midrst_sum",   bus4.sum,   0);
    check("midrst_co",    bus4.co,    0);
    check("midrst_add_a", bus4.add_a, 0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus4.done) ndone++;
      tick;
    end
    check("midrst_no_done", ndone, 0);
    run4(16'h0F0F, 16'h0101, 1'b0, cyc, sa, sci);
    check("postrst_latency", cyc, 4);
    check("postrst_sum", bus4.sum, 16'h1010);
    check("postrst_co", bus4.co, 0);
    tick;

    // start held high: one result every NIBBLES+1 cycles
    bus4.a = cont[0].a; bus4.b = cont[0].b; bus4.ci = cont[0].ci; bus4.start = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      while (!bus4.done && cyc < 20) begin
        tick;
        cyc++;
      end
      check($sformatf("c%0d_latency", i), cyc, 4);
      check($sformatf("c%0d_sum", i), bus4.sum, cont[i].sum);
      check($sformatf("c%0d_co", i), bus4.co, cont[i].co);
      check($sformatf("c%0d_ovf", i), bus4.ovf, cont[i].ovf);
      if (i < 3) begin
        bus4.a = cont[i+1].a; bus4.b = cont[i+1].b; bus4.ci = cont[i+1].ci;
        tick;
        check($sformatf("c%0d_reaccept", i), bus4.busy, 1);
      end
    end
    bus4.start = 1'b0;
    tick;

    // NIBBLES=1 exhaustive
    for (int x = 0; x < 512; x++) begin
      bus1.a = x[3:0]; bus1.b = x[7:4]; bus1.ci = x[8]; bus1.start = 1'b1;
      tick;
      bus1.start = 1'b0;
      tick;
      expv = x[3:0] + x[7:4] + x[8];
      check($sformatf("n1_%0d", x), {bus1.done, bus1.co, bus1.sum}, {1'b1, 5'(expv)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
